// File: rtl/controlador_display.sv
// Multiplexed scan controller for a common-segment display sharing one external hex decoder.
// Shadow/active digit banks with a commit handshake give atomic updates at frame boundaries.
module controlador_display #(
    parameter int unsigned N_DIG   = 4,
    parameter int unsigned T_DIG   = 1000,
    parameter int unsigned T_BLANK = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [$clog2(N_DIG)-1:0] wr_idx,
    input  logic [4:0]               wr_data,
    input  logic                     commit,
    output logic                     commit_pend,
    output logic [3:0]               data_dec,
    input  logic [0:6]               display_dec,
    output logic [N_DIG-1:0]         an,
    output logic [0:6]               seg,
    output logic                     frame_start
);

    localparam int unsigned DigW = $clog2(N_DIG);
    localparam int unsigned TMax = (T_DIG > T_BLANK) ? T_DIG : T_BLANK;
    localparam int unsigned CntW = $clog2(TMax + 1);

    typedef enum logic {StBlank, StShow} state_e;

    state_e          state_q, state_d;
    logic [DigW-1:0] dig_q, dig_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      shadow_q [N_DIG];
    logic [4:0]      shadow_d [N_DIG];
    logic [4:0]      active_q [N_DIG];
    logic [4:0]      active_d [N_DIG];
    logic            commit_pend_q, commit_pend_d;
    logic            frame_start_q, frame_start_d;
    logic [3:0]      data_dec_q, data_dec_d;
    logic [N_DIG-1:0] an_q, an_d;
    logic [0:6]      seg_q, seg_d;

    always_comb begin
        state_d       = state_q;
        dig_d         = dig_q;
        cnt_d         = cnt_q + 1'b1;
        shadow_d      = shadow_q;
        active_d      = active_q;
        commit_pend_d = commit_pend_q | commit;
        frame_start_d = 1'b0;
        data_dec_d    = data_dec_q;
        an_d          = an_q;
        seg_d         = seg_q;

        // Out-of-range indices match no digit and are dropped.
        for (int i = 0; i < N_DIG; i++) begin
            if (wr_en && (wr_idx == DigW'(i))) begin
                shadow_d[i] = wr_data;
            end
        end

        unique case (state_q)
            StBlank: begin
                if (cnt_q == CntW'(T_BLANK - 1)) begin
                    state_d = StShow;
                    cnt_d   = '0;
                    for (int i = 0; i < N_DIG; i++) begin
                        an_d[i] = (dig_q != DigW'(i));
                    end
                    seg_d = active_q[dig_q][4] ? 7'b1111111 : display_dec;
                end
            end
            StShow: begin
                if (cnt_q == CntW'(T_DIG - 1)) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    an_d    = '1;
                    seg_d   = '1;
                    if (dig_q == DigW'(N_DIG - 1)) begin
                        // Frame boundary: copy uses pre-edge shadow, so a write now misses it.
                        dig_d         = '0;
                        frame_start_d = 1'b1;
                        commit_pend_d = commit;
                        if (commit_pend_q) begin
                            active_d = shadow_q;
                        end
                    end else begin
                        dig_d = dig_q + 1'b1;
                    end
                    data_dec_d = active_d[dig_d][3:0];
                end
            end
            default: state_d = StBlank;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StBlank;
            dig_q         <= '0;
            cnt_q         <= '0;
            commit_pend_q <= 1'b0;
            frame_start_q <= 1'b0;
            data_dec_q    <= '0;
            an_q          <= '1;
            seg_q         <= '1;
            for (int i = 0; i < N_DIG; i++) begin
                shadow_q[i] <= 5'b10000;
                active_q[i] <= 5'b10000;
            end
        end else begin
            state_q       <= state_d;
            dig_q         <= dig_d;
            cnt_q         <= cnt_d;
            commit_pend_q <= commit_pend_d;
            frame_start_q <= frame_start_d;
            data_dec_q    <= data_dec_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    assign commit_pend = commit_pend_q;
    assign frame_start = frame_start_q;
    assign data_dec    = data_dec_q;
    assign an          = an_q;
    assign seg         = seg_q;

endmodule

// File: tb/tb_controlador_display.sv
// Bench for controlador_display: external hex decoder model plus a frame-position reference
// model derived from cycle counts since reset.
module tb_controlador_display;

    localparam int unsigned NDig   = 4;
    localparam int unsigned TDig   = 4;
    localparam int unsigned TBlank = 2;
    localparam int          DigPer = TDig + TBlank;
    localparam int          FrmPer = NDig * DigPer;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            wr_en = 1'b0;
    logic [1:0]      wr_idx = '0;
    logic [4:0]      wr_data = '0;
    logic            commit = 1'b0;
    logic            commit_pend;
    logic [3:0]      data_dec;
    logic [0:6]      display_dec;
    logic [NDig-1:0] an;
    logic [0:6]      seg;
    logic            frame_start;

    int nerr = 0;
    int nchecks = 0;

    // Reference model state
    int         t = 0;
    logic [4:0] m_shadow [NDig];
    logic [4:0] m_active [NDig];
    bit         m_pend = 1'b0;

    always #5 clock = ~clock;

    function automatic logic [0:6] dec7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    assign display_dec = dec7(data_dec);

    controlador_display #(
        .N_DIG  (NDig),
        .T_DIG  (TDig),
        .T_BLANK(TBlank)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .commit     (commit),
        .commit_pend(commit_pend),
        .data_dec   (data_dec),
        .display_dec(display_dec),
        .an         (an),
        .seg        (seg),
        .frame_start(frame_start)
    );

    // Expected {an, seg, data_dec, commit_pend, frame_start} from the position in the frame.
    function automatic logic [16:0] exp_vec();
        int p, d, q;
        logic [3:0] ea;
        logic [0:6] es;
        p  = t % FrmPer;
        d  = p / DigPer;
        q  = p % DigPer;
        ea = 4'hF;
        es = 7'b1111111;
        if (q >= TBlank) begin
            ea[d] = 1'b0;
            if (!m_active[d][4]) es = dec7(m_active[d][3:0]);
        end
        return {ea, es, m_active[d][3:0], m_pend, (p == 0 && t > 0)};
    endfunction

    function automatic logic [16:0] act_vec();
        return {an, seg, data_dec, commit_pend, frame_start};
    endfunction

    task automatic model_reset();
        t = 0;
        m_pend = 1'b0;
        for (int i = 0; i < NDig; i++) begin
            m_shadow[i] = 5'b10000;
            m_active[i] = 5'b10000;
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] idx, input logic [4:0] dat,
                         input logic cm);
        wr_en = we;
        wr_idx = idx;
        wr_data = dat;
        commit = cm;
    endtask

    // One clock edge; the model absorbs the inputs present at that edge.
    task automatic cycle();
        @(posedge clock);
        if (((t + 1) % FrmPer) == 0) begin
            if (m_pend) m_active = m_shadow;
            m_pend = commit;
        end else if (commit) begin
            m_pend = 1'b1;
        end
        if (wr_en) m_shadow[wr_idx] = wr_data;
        t++;
        #1;
    endtask

    task automatic test_reset();
        int first_fs;
        first_fs = -1;
        model_reset();
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        nchecks++;
        if (act_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL reset_state: got %h expected %h", act_vec(), exp_vec());
        end
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (frame_start && first_fs < 0) first_fs = t;
            nchecks++;
            if (act_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL idle_scan t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            end
        end
        nchecks++;
        if (first_fs !== 24) begin
            nerr++;
            $display("FAIL first_frame_start: got cycle %0d expected 24", first_fs);
        end
    endtask

    task automatic test_commit_digits();
        logic [10:0] k [4];
        k[0] = {4'b1110, 7'b1001111};
        k[1] = {4'b1101, 7'b0010010};
        k[2] = {4'b1011, 7'b0000110};
        k[3] = {4'b0111, 7'b1001100};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, 2'(i), 5'(i + 1), 1'b0);
            else drive(1'b0, 2'd0, 5'd0, 1'b1);
            cycle();
            nchecks++;
            if (act_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL write_commit t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            end
        end
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        nchecks++;
        if (commit_pend !== 1'b1) begin
            nerr++;
            $display("FAIL commit_pend_set: got %b expected 1", commit_pend);
        end
        while ((t % FrmPer) != 0) begin
            cycle();
            nchecks++;
            if (act_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL pend_wait t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            end
        end
        for (int i = 0; i < FrmPer; i++) begin
            if ((i % DigPer) == TBlank) begin
                nchecks++;
                if ({an, seg} !== k[i / DigPer]) begin
                    nerr++;
                    $display("FAIL digit_%0d_shown: got %h expected %h", i / DigPer, {an, seg},
                             k[i / DigPer]);
                end
            end
            cycle();
            nchecks++;
            if (act_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL shown_frame t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_no_commit();
        drive(1'b1, 2'd1, 5'h08, 1'b0);
        cycle();
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3 * FrmPer; i++) begin
            cycle();
            nchecks++;
            if (act_vec() !== exp_vec() || commit_pend !== 1'b0) begin
                nerr++;
                $display("FAIL uncommitted t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            end
        end
        drive(1'b0, 2'd0, 5'd0, 1'b1);
        cycle();
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        for (int i = 0; i < 2 * FrmPer; i++) begin
            cycle();
            if ((t % FrmPer) == DigPer + TBlank && m_pend == 1'b0) begin
                nchecks++;
                if (seg !== 7'b0000000) begin
                    nerr++;
                    $display("FAIL digit1_eight: got %b expected 0000000", seg);
                end
            end
            nchecks++;
            if (act_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL commit_later t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_commit_on_wrap();
        while ((t % FrmPer) != FrmPer - 1) begin
            cycle();
        end
        drive(1'b1, 2'd2, 5'h10, 1'b1);
        cycle();
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        nchecks++;
        if (commit_pend !== 1'b1) begin
            nerr++;
            $display("FAIL wrap_commit_pending: got %b expected 1", commit_pend);
        end
        for (int i = 0; i < 2 * FrmPer; i++) begin
            if ((t % FrmPer) == 2 * DigPer + TBlank) begin
                nchecks++;
                if (seg !== (i < FrmPer ? 7'b0000110 : 7'b1111111)) begin
                    nerr++;
                    $display("FAIL wrap_digit2 frame=%0d: got %b", i / FrmPer, seg);
                end
            end
            cycle();
            nchecks++;
            if (act_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL wrap_frames t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_blank_flag();
        drive(1'b1, 2'd0, 5'h1A, 1'b1);
        cycle();
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        for (int i = 0; i < 2 * FrmPer; i++) begin
            cycle();
            if ((t % FrmPer) == TBlank && m_pend == 1'b0) begin
                nchecks++;
                if (an[0] !== 1'b0 || seg !== 7'b1111111) begin
                    nerr++;
                    $display("FAIL blank_flag: got an=%b seg=%b expected an[0]=0 seg=1111111",
                             an, seg);
                end
            end
            nchecks++;
            if (act_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL blank_frames t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FrmPer; i++) begin
            drive(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 5'($urandom),
                  ($urandom_range(0, 9) == 0));
            cycle();
            nchecks++;
            if (act_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL random t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            end
        end
        drive(1'b0, 2'd0, 5'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 2'd3, 5'h07, 1'b1);
        cycle();
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        while (((t % FrmPer) % DigPer) < TBlank + 1) begin
            cycle();
        end
        #2;
        resetn = 1'b0;
        #1;
        nchecks++;
        if (an !== 4'hF || seg !== 7'b1111111 || commit_pend !== 1'b0) begin
            nerr++;
            $display("FAIL mid_reset: got an=%b seg=%b pend=%b expected 1111 1111111 0",
                     an, seg, commit_pend);
        end
        model_reset();
        @(posedge clock);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 2 * FrmPer; i++) begin
            cycle();
            nchecks++;
            if (act_vec() !== exp_vec() || seg !== 7'b1111111) begin
                nerr++;
                $display("FAIL post_reset t=%0d: got %h expected %h", t, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_commit_digits();
        test_no_commit();
        test_commit_on_wrap();
        test_blank_flag();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/controlador_display.md
# controlador_display

Time-multiplexed scan controller for the 4-bit-to-7-segment decoder (`decodificador`). It holds one 4-bit value per digit and feeds them one at a time through a single shared decoder instance. It then drives the segment bus and the per-digit enables of a common-segment multi-digit display. Double-buffered digit registers with a commit handshake make multi-digit updates appear atomically at frame boundaries.

## Interface
- `N_DIG`, 4: number of digits scanned (2..8).
- `T_DIG`, 1000: clock cycles each digit is lit (>=1).
- `T_BLANK`, 16: clock cycles of anti-ghosting blank before each digit (>=1).

- `clock`  in  1  single clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe into shadow registers.
- `wr_idx`  in  $clog2(N_DIG)  shadow digit index; indices >= N_DIG are ignored.
- `wr_data`  in  5  bit 4 = blank flag, bits 3:0 = hex value.
- `commit`  in  1  request shadow-to-active copy at next frame boundary.
- `commit_pend`  out  1  commit requested but not yet applied.
- `data_dec`  out  4  value to shared decoder input.
- `display_dec`  in  7 [0:6]  decoder output, active-low segments a..g.
- `an`  out  N_DIG  digit enables, active-low, one-hot-low when lit.
- `seg`  out  7 [0:6]  segment bus, active-low (1 = off).
- `frame_start`  out  1  one-cycle pulse at the start of each frame.

## Operation
- Storage: `shadow[N_DIG]` and `active[N_DIG]`, 5 bits each. `dig` is the current digit (0..N_DIG-1). `cnt` is the phase counter.
- FSM has two states:
  - BLANK: `an` all ones, `seg` all ones, `data_dec` = `active[dig][3:0]`. After T_BLANK cycles it goes to SHOW.
  - SHOW: `an[dig]`=0 and all other enables 1. `seg` = 7'b1111111 if `active[dig][4]`, else the `display_dec` value captured on the BLANK->SHOW edge. After T_DIG cycles it goes to BLANK with `dig`+1.
- Wrap: SHOW of `dig`=N_DIG-1 -> BLANK of `dig`=0. This is the frame boundary (the wrap edge).
  - At the wrap edge, if `commit_pend`=1, `active` <= `shadow` (pre-edge values).
  - At the wrap edge, `frame_start` is set for exactly one cycle.
- Writes: `wr_en`=1 at an edge sets `shadow[wr_idx]` <= `wr_data`. Writes are always accepted and never stall.
- Commit:
  - `commit`=1 at an edge sets `commit_pend`.
  - At the wrap edge, `commit_pend` <= `commit`. A commit that coincides with the wrap stays pending for the following frame.
  - A write at the wrap edge is not included in that copy.
- `data_dec` is registered and changes only on the edge entering BLANK, so the decoder settles for T_BLANK cycles before capture.

## Timing
- Reset (async assert, sync to first edge after deassert):
  - FSM=BLANK, `dig`=0, `cnt`=0.
  - `an`=all ones, `seg`=7'b1111111, `data_dec`=0.
  - all `shadow` and `active`=5'b10000 (blank).
  - `commit_pend`=0, `frame_start`=0.
- After reset, the first BLANK lasts T_BLANK cycles. No `frame_start` pulse occurs for the post-reset frame; the first pulse follows the first wrap.
- Digit period = T_BLANK+T_DIG cycles. Frame period = N_DIG*(T_BLANK+T_DIG).
- `an` and `seg` are registered and switch on the same edge; no cycle has a lit digit with stale segments.
- Write-to-visible latency: write, then commit, then next wrap edge, then T_BLANK cycles until digit 0 lights.
- Reset asserted mid-frame immediately blanks the display (`an`/`seg` all ones) and discards the pending commit.

## Test plan
- Run with N_DIG=4, T_DIG=4, T_BLANK=2:
  - After reset, hold idle for 30 cycles -> `an`=4'b1111 in BLANK and one-hot-low in SHOW, `seg`=7'b1111111 throughout, first `frame_start` at cycle 24.
  - Write idx0..3 = 1,2,3,4 (blank=0), then commit -> `commit_pend`=1 until wrap. Next frame shows `seg` 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100 with `an` 1110, 1101, 1011, 0111.
  - Write idx1=5'h08 without commit -> display unchanged for 3 frames and `commit_pend`=0. Then commit -> digit 1 shows 7'b0000000 from the next frame.
  - Assert `commit` and write idx2=5'h10 on the wrap edge -> that frame uses the old idx2 and `commit_pend` stays 1. The following frame blanks digit 2.
  - Write idx0=5'h1A (blank set) and commit -> digit 0 `seg`=7'b1111111 while `an[0]`=0.
  - Pull `resetn` low mid-SHOW -> `an`/`seg` all ones immediately. After release, the display stays blank until a new write and commit.
